// File: rtl/ysyx_22041412_mem_pkg.sv
// Shared definitions for the NPC data memory: func3 encodings, FSM states
// and the access-size helper.
package ysyx_22041412_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  // Access size in bytes; the low two func3 bits encode it for loads and stores
  function automatic logic [3:0] size_bytes(input logic [2:0] func3);
    case (func3[1:0])
      2'b00:   size_bytes = 4'd1;
      2'b01:   size_bytes = 4'd2;
      2'b10:   size_bytes = 4'd4;
      default: size_bytes = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22041412_lsu_align.sv
// Byte-lane alignment for the data memory: store mask/shift, load
// shift/extension, and misalignment / illegal-func3 detection.
module ysyx_22041412_lsu_align
  import ysyx_22041412_mem_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [2:0]  addr_lo,
  input  logic        we,
  input  logic [63:0] wdata,
  input  logic [63:0] rdata_raw,
  output logic [7:0]  wmask,
  output logic [63:0] wdata_sh,
  output logic [63:0] rdata_ext,
  output logic        misalign,
  output logic        illegal
);

  logic [3:0]  sz;
  logic [7:0]  size_mask;
  logic [63:0] rsh;

  // Lane mask, shifted data and error flags for the current access
  always_comb begin
    sz = size_bytes(func3);
    case (func3[1:0])
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
    wmask    = size_mask << addr_lo;
    wdata_sh = wdata << {addr_lo, 3'b000};
    misalign = ({1'b0, addr_lo} & (sz - 4'd1)) != 4'd0;
    illegal  = we ? func3[2] : (func3 == 3'b111);
  end

  // Right-justify the loaded bytes, then sign- or zero-extend to 64 bits
  always_comb begin
    rsh = rdata_raw >> {addr_lo, 3'b000};
    case (func3)
      F3_B:    rdata_ext = {{56{rsh[7]}}, rsh[7:0]};
      F3_H:    rdata_ext = {{48{rsh[15]}}, rsh[15:0]};
      F3_W:    rdata_ext = {{32{rsh[31]}}, rsh[31:0]};
      F3_BU:   rdata_ext = {56'd0, rsh[7:0]};
      F3_HU:   rdata_ext = {48'd0, rsh[15:0]};
      F3_WU:   rdata_ext = {32'd0, rsh[31:0]};
      default: rdata_ext = rsh;
    endcase
  end

endmodule

// File: rtl/ysyx_22041412_dmem.sv
// On-chip byte-addressable data memory with a valid/ready request port and a
// fixed-latency valid/ready response port.
module ysyx_22041412_dmem
  import ysyx_22041412_mem_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 64,
  parameter int unsigned           DATA_WIDTH = 64,
  parameter int unsigned           DATA_DEPTH = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 64'h8000_0000,
  parameter int unsigned           LATENCY    = 1
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [2:0]            req_func3,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  localparam int unsigned IDX_W = $clog2(DATA_DEPTH);
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t                state_q, state_d;
  logic                  req_ready_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            f3_q;
  logic [63:0]           wdata_q;
  logic [63:0]           rdata_q;
  logic                  err_q;

  logic [63:0]           mem [DATA_DEPTH];

  logic [ADDR_WIDTH-4:0] offset_hi;
  logic [IDX_W-1:0]      idx;
  logic                  oor;
  logic                  accept;
  logic                  access;
  logic                  err;
  logic [7:0]            wmask;
  logic [63:0]           wdata_sh;
  logic [63:0]           rdata_ext;
  logic                  misalign;
  logic                  illegal;

  // Word index computed on the 8-byte-granular part of the address; BASE_ADDR is word aligned
  always_comb begin
    offset_hi = addr_q[ADDR_WIDTH-1:3] - BASE_ADDR[ADDR_WIDTH-1:3];
    idx       = offset_hi[IDX_W-1:0];
    oor       = (addr_q < BASE_ADDR) || ((offset_hi >> IDX_W) != '0);
    accept    = (state_q == IDLE) && req_valid && req_ready_q;
    access    = (state_q == BUSY) && (cnt_q == '0);
    err       = misalign || illegal || oor;
  end

  ysyx_22041412_lsu_align u_align (
    .func3     (f3_q),
    .addr_lo   (addr_q[2:0]),
    .we        (we_q),
    .wdata     (wdata_q),
    .rdata_raw (mem[idx]),
    .wmask     (wmask),
    .wdata_sh  (wdata_sh),
    .rdata_ext (rdata_ext),
    .misalign  (misalign),
    .illegal   (illegal)
  );

  // Next-state and handshake outputs
  always_comb begin
    state_d   = state_q;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (cnt_q == '0) state_d = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = req_ready_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // State register; req_ready is registered so it stays low throughout reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= (state_d == IDLE);
    end
  end

  // Request latch, latency counter and registered response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      f3_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        f3_q    <= req_func3;
        wdata_q <= req_wdata;
        cnt_q   <= CNT_W'(LATENCY - 1);
      end else if ((state_q == BUSY) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (access) begin
        err_q   <= err;
        rdata_q <= (we_q || err) ? '0 : rdata_ext;
      end
    end
  end

  // Storage array: lane-masked store commit, never on error
  always_ff @(posedge clk) begin
    if (access && we_q && !err) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (wmask[i]) mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22041412_dmem.sv
// Scoreboard bench for the data memory: the stimulus thread queues expected
// responses, the monitor pops and compares on each response handshake.
module tb_ysyx_22041412_dmem;
  import ysyx_22041412_mem_pkg::*;

  localparam int unsigned LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [63:0] req_addr = '0;
  logic [2:0]  req_func3 = '0;
  logic [63:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  typedef struct {
    string       name;
    logic        err;
    logic [63:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  ysyx_22041412_dmem #(
    .ADDR_WIDTH (64),
    .DATA_WIDTH (64),
    .DATA_DEPTH (4096),
    .BASE_ADDR  (64'h8000_0000),
    .LATENCY    (LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_func3 (req_func3),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare every consumed response against the head of the queue
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rsp: got rdata=%h err=%b expected no response", rsp_rdata, rsp_err);
      end else begin
        mon_e = exp_q.pop_front();
        check({mon_e.name, "_data"}, rsp_rdata, mon_e.data);
        check({mon_e.name, "_err"}, {63'd0, rsp_err}, {63'd0, mon_e.err});
      end
    end
  end

  // Issue one request (caller is just after a rising edge) and wait for rsp_valid
  task automatic send(input string name, input logic we, input logic [2:0] f3,
                      input logic [63:0] addr, input logic [63:0] wd,
                      input logic [63:0] ed, input logic ee);
    exp_t        e;
    int unsigned w;
    int unsigned lat;
    e.name = name;
    e.err  = ee;
    e.data = ed;
    exp_q.push_back(e);
    req_we    = we;
    req_func3 = f3;
    req_addr  = addr;
    req_wdata = wd;
    req_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_accept: got req_ready=0 expected 1 within 20 cycles", name);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      @(posedge clk);
      #1 lat++;
    end
    check({name, "_lat"}, 64'(lat), 64'(LAT));
  endtask

  task automatic xfer(input string name, input logic we, input logic [2:0] f3,
                      input logic [63:0] addr, input logic [63:0] wd,
                      input logic [63:0] ed, input logic ee);
    send(name, we, f3, addr, wd, ed, ee);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    rsp_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {63'd0, req_ready}, 64'd0);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_rsp_rdata", rsp_rdata, 64'd0);
    check("rst_rsp_err", {63'd0, rsp_err}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_req_ready", {63'd0, req_ready}, 64'd1);
    @(posedge clk);
    #1;

    // Basic store / load
    xfer("sd_10",  1'b1, F3_D,  64'h8000_0010, 64'h1122_3344_5566_7788, 64'd0, 1'b0);
    xfer("ld_10",  1'b0, F3_D,  64'h8000_0010, 64'd0, 64'h1122_3344_5566_7788, 1'b0);
    xfer("lbu_17", 1'b0, F3_BU, 64'h8000_0017, 64'd0, 64'h11, 1'b0);
    xfer("lh_12",  1'b0, F3_H,  64'h8000_0012, 64'd0, 64'h5566, 1'b0);

    // Sign / zero extension
    xfer("sb_20",  1'b1, F3_B,  64'h8000_0020, 64'h80, 64'd0, 1'b0);
    xfer("lb_20",  1'b0, F3_B,  64'h8000_0020, 64'd0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
    xfer("lbu_20", 1'b0, F3_BU, 64'h8000_0020, 64'd0, 64'h80, 1'b0);
    xfer("sw_24",  1'b1, F3_W,  64'h8000_0024, 64'h8000_0000, 64'd0, 1'b0);
    xfer("lw_24",  1'b0, F3_W,  64'h8000_0024, 64'd0, 64'hFFFF_FFFF_8000_0000, 1'b0);
    xfer("lwu_24", 1'b0, F3_WU, 64'h8000_0024, 64'd0, 64'h0000_0000_8000_0000, 1'b0);

    // Byte mask
    xfer("sd_30",  1'b1, F3_D,  64'h8000_0030, 64'd0, 64'd0, 1'b0);
    xfer("sh_32",  1'b1, F3_H,  64'h8000_0032, 64'hABCD, 64'd0, 1'b0);
    xfer("ld_30",  1'b0, F3_D,  64'h8000_0030, 64'd0, 64'h0000_0000_ABCD_0000, 1'b0);

    // Errors and range boundaries
    xfer("lw_mis",     1'b0, F3_W,   64'h8000_0002, 64'd0, 64'd0, 1'b1);
    xfer("sd_last",    1'b1, F3_D,   64'h8000_7FF8, 64'h0123_4567_89AB_CDEF, 64'd0, 1'b0);
    xfer("ld_last",    1'b0, F3_D,   64'h8000_7FF8, 64'd0, 64'h0123_4567_89AB_CDEF, 1'b0);
    xfer("sd_below",   1'b1, F3_D,   64'h7FFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
    xfer("ld_last2",   1'b0, F3_D,   64'h8000_7FF8, 64'd0, 64'h0123_4567_89AB_CDEF, 1'b0);
    xfer("ld_f3_111",  1'b0, 3'b111, 64'h8000_0010, 64'd0, 64'd0, 1'b1);
    xfer("st_f3_100",  1'b1, 3'b100, 64'h8000_0010, 64'd0, 64'd0, 1'b1);
    xfer("ld_10_keep", 1'b0, F3_D,   64'h8000_0010, 64'd0, 64'h1122_3344_5566_7788, 1'b0);
    xfer("ld_oor",     1'b0, F3_D,   64'h8000_8000, 64'd0, 64'd0, 1'b1);
    xfer("sw_mis",     1'b1, F3_W,   64'h8000_0032, 64'h1234_5678, 64'd0, 1'b1);
    xfer("ld_30_keep", 1'b0, F3_D,   64'h8000_0030, 64'd0, 64'h0000_0000_ABCD_0000, 1'b0);

    // Response backpressure: outputs held while rsp_ready is low
    rsp_ready = 1'b0;
    send("bp_ld", 1'b0, F3_D, 64'h8000_0010, 64'd0, 64'h1122_3344_5566_7788, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", {63'd0, rsp_valid}, 64'd1);
      check("bp_rsp_rdata", rsp_rdata, 64'h1122_3344_5566_7788);
      check("bp_req_ready", {63'd0, req_ready}, 64'd0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset during BUSY of a store: the store must be dropped
    req_we    = 1'b1;
    req_func3 = F3_D;
    req_addr  = 64'h8000_0010;
    req_wdata = 64'hDEAD_BEEF_CAFE_F00D;
    req_valid = 1'b1;
    @(negedge clk);
    check("mid_rst_ready", {63'd0, req_ready}, 64'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_req_ready", {63'd0, req_ready}, 64'd0);
    check("mid_rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    xfer("ld_after_rst", 1'b0, F3_D, 64'h8000_0010, 64'd0, 64'h1122_3344_5566_7788, 1'b0);

    repeat (5) @(posedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
